// File: rtl/fp_addsub_stream.sv
// Streaming wrapper around a fixed-latency FP add/sub unit with credit-based admission and a show-ahead result FIFO.
// Optional sticky flag accumulation is built when FPAS_STREAM_STICKY_EN is defined.
module fp_addsub_stream #(
   parameter int LATENCY = 9,
   parameter int DEPTH   = 16,
   parameter int TAGW    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_a,
   input  logic [31:0]     in_b,
   input  logic            in_op,
   input  logic [TAGW-1:0] in_tag,
   output logic [31:0]     fpu_a,
   output logic [31:0]     fpu_b,
   output logic            fpu_operation,
   output logic            fpu_rst,
   input  logic [31:0]     fpu_result,
   input  logic [4:0]      fpu_flags,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_result,
   output logic [4:0]      out_flags,
   output logic [TAGW-1:0] out_tag,
   output logic            busy,
   output logic [4:0]      sticky_flags,
   input  logic            sticky_clr
);
   // One slot for the operand register plus LATENCY adder stages, so the last
   // slot lines up with the cycle in which the adder presents the matching result.
   localparam int NS = LATENCY + 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = 32 + 5 + TAGW;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [7:0]    DEPTH_C  = 8'(DEPTH);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   logic            accept, push, pop;
   logic [7:0]      inflight, credit_used;
   logic [31:0]     fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
   logic            fpu_op_q, fpu_op_d;
   logic [NS-1:0]   sr_vld_q, sr_vld_d;
   logic [TAGW-1:0] sr_tag_q [NS];
   logic [TAGW-1:0] sr_tag_d [NS];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [EW-1:0]   fifo_mem_q [DEPTH];
   logic [EW-1:0]   head;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < NS; i++) inflight = inflight + 8'(sr_vld_q[i]);
   end

   // Credit is computed from registered state only, so a pop frees it one cycle later.
   assign credit_used = 8'(count_q) + inflight;
   assign in_ready    = credit_used < DEPTH_C;
   assign accept      = in_valid & in_ready;
   assign out_valid   = (count_q != '0);
   assign pop         = out_valid & out_ready;
   assign push        = sr_vld_q[NS-1];
   assign busy        = (inflight != 8'd0) | out_valid;
   assign fpu_rst     = rst;

   // Operand stage
   always_comb begin
      fpu_a_d  = fpu_a_q;
      fpu_b_d  = fpu_b_q;
      fpu_op_d = fpu_op_q;
      if (accept) begin
         fpu_a_d  = in_a;
         fpu_b_d  = in_b;
         fpu_op_d = in_op;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpu_a_q  <= '0;
         fpu_b_q  <= '0;
         fpu_op_q <= 1'b0;
      end else begin
         fpu_a_q  <= fpu_a_d;
         fpu_b_q  <= fpu_b_d;
         fpu_op_q <= fpu_op_d;
      end
   end

   assign fpu_a         = fpu_a_q;
   assign fpu_b         = fpu_b_q;
   assign fpu_operation = fpu_op_q;

   // In-flight tracking stage
   always_comb begin
      sr_vld_d    = {sr_vld_q[NS-2:0], accept};
      sr_tag_d[0] = in_tag;
      for (int i = 1; i < NS; i++) sr_tag_d[i] = sr_tag_q[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_vld_q <= '0;
      else     sr_vld_q <= sr_vld_d;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NS; i++) sr_tag_q[i] <= sr_tag_d[i];
   end

   // Result FIFO stage
   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= {fpu_flags, sr_tag_q[NS-1], fpu_result};
   end

   always_ff @(posedge clk) begin
      if (!rst && push) assert (count_q != CW'(DEPTH)) else $error("result FIFO push while full");
   end

   // Storage is not reset, so the head is masked to zero while empty.
   assign head       = fifo_mem_q[rd_ptr_q];
   assign out_result = out_valid ? head[31:0] : '0;
   assign out_tag    = out_valid ? head[32 +: TAGW] : '0;
   assign out_flags  = out_valid ? head[EW-1 -: 5] : '0;

`ifdef FPAS_STREAM_STICKY_EN
   logic [4:0] sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_clr ? 5'b0 : sticky_q;
      if (pop) sticky_d = sticky_d | out_flags;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sticky_q <= '0;
      else     sticky_q <= sticky_d;
   end

   assign sticky_flags = sticky_q;
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign sticky_flags      = 5'b0;
`endif

endmodule

// File: tb/tb_fp_addsub_stream.sv
// Bench for fp_addsub_stream: stand-in adder, scoreboard of accepted requests, directed and random traffic.
module tb_fp_addsub_stream;
   localparam int LAT  = 9;
   localparam int DEP  = 16;
   localparam int TW   = 4;
`ifdef FPAS_STREAM_STICKY_EN
   localparam logic [4:0] STK_OVF = 5'h10;
`else
   localparam logic [4:0] STK_OVF = 5'h00;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_op, out_valid, out_ready, busy, sticky_clr;
   logic [31:0]   in_a, in_b, fpu_a, fpu_b, fpu_result, out_result;
   logic [TW-1:0] in_tag, out_tag;
   logic          fpu_operation, fpu_rst;
   logic [4:0]    fpu_flags, out_flags, sticky_flags;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [4:0]    flg;
      logic [31:0]   res;
   } exp_t;

   exp_t       exp_q[$];
   logic [4:0] sticky_m;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   fp_addsub_stream #(.LATENCY(LAT), .DEPTH(DEP), .TAGW(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_tag(in_tag),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_operation(fpu_operation), .fpu_rst(fpu_rst),
      .fpu_result(fpu_result), .fpu_flags(fpu_flags),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_flags(out_flags), .out_tag(out_tag), .busy(busy),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
   );

   // Stand-in adder: known answers for the cases that matter, an arbitrary mix otherwise.
   function automatic logic [36:0] adder_ref(input logic [31:0] a, input logic [31:0] b, input logic op);
      if (!op && a == 32'h3F800000 && b == 32'h40000000) return {5'h00, 32'h40400000};
      if (!op && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {5'h10, 32'h7F800000};
      return {a[4:0] ^ b[9:5], op ? a - b : a + b};
   endfunction

   logic [36:0] adder_pipe [LAT];
   always @(posedge clk) begin
      adder_pipe[0] <= adder_ref(fpu_a, fpu_b, fpu_operation);
      for (int k = 1; k < LAT; k++) adder_pipe[k] <= adder_pipe[k-1];
   end
   assign fpu_result = adder_pipe[LAT-1][31:0];
   assign fpu_flags  = adder_pipe[LAT-1][36:32];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: requests accepted and results popped, in order, with the sticky register model.
   always @(negedge clk) begin
      exp_t e;
      logic [36:0] r;
      if (rst) begin
         exp_q.delete();
         sticky_m = 5'b0;
      end else begin
         check_val("sticky", {59'b0, sticky_flags}, {59'b0, sticky_m});
`ifdef FPAS_STREAM_STICKY_EN
         if (sticky_clr) sticky_m = 5'b0;
`endif
         if (in_valid && in_ready) begin
            r = adder_ref(in_a, in_b, in_op);
            exp_q.push_back('{tag: in_tag, flg: r[36:32], res: r[31:0]});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("pop_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_val("out_result", {32'b0, out_result}, {32'b0, e.res});
               check_val("out_flags", {59'b0, out_flags}, {59'b0, e.flg});
               check_val("out_tag", {60'b0, out_tag}, {60'b0, e.tag});
`ifdef FPAS_STREAM_STICKY_EN
               sticky_m = sticky_m | e.flg;
`endif
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      check_val("idle_timeout", 1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc, cyc, ov_cnt, first_hi, last_hi, found, n;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
      out_ready = 1'b0; sticky_clr = 1'b0;
      repeat (2) @(negedge clk);
      check_val("fpu_rst_fwd", {63'b0, fpu_rst}, 1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_in_ready", {63'b0, in_ready}, 1);
      check_val("rst_out_valid", {63'b0, out_valid}, 0);
      check_val("rst_busy", {63'b0, busy}, 0);
      check_val("rst_out_result", {32'b0, out_result}, 0);
      check_val("rst_out_flags", {59'b0, out_flags}, 0);
      check_val("rst_out_tag", {60'b0, out_tag}, 0);
      check_val("rst_fpu_a", {32'b0, fpu_a}, 0);

      // Single request: 1.0 + 2.0, result ten cycles after the accept edge.
      step();
      out_ready = 1'b1; in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_tag = 4'd3;
      step();
      in_valid = 1'b0;
      found = 0; n = 0;
      for (int i = 1; i <= 25 && found == 0; i++) begin
         @(negedge clk);
         if (out_valid) begin found = 1; n = i - 1; end
      end
      check_val("lat_found", 64'(found), 1);
      check_val("lat_cycles", 64'(n), 10);
      check_val("lat_result", {32'b0, out_result}, 64'h40400000);
      check_val("lat_flags", {59'b0, out_flags}, 0);
      check_val("lat_tag", {60'b0, out_tag}, 3);
      wait_idle();

      // Fill credit with the consumer stalled, then release it.
      step();
      out_ready = 1'b0; in_valid = 1'b1; acc = 0;
      for (int i = 0; i < 30; i++) begin
         in_tag = TW'(acc); in_a = $urandom; in_b = $urandom; in_op = 1'($urandom);
         @(negedge clk);
         if (in_ready) acc++;
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_val("fill_accepts", 64'(acc), 16);
      check_val("fill_ready_low", {63'b0, in_ready}, 0);
      check_val("fill_out_valid", {63'b0, out_valid}, 1);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      check_val("credit_before_pop", {63'b0, in_ready}, 0);
      @(negedge clk);
      check_val("credit_after_pop", {63'b0, in_ready}, 1);
      wait_idle();

      // Back-to-back issue with a free-running consumer.
      step();
      out_ready = 1'b1; in_valid = 1'b1;
      cyc = 0; ov_cnt = 0; first_hi = -1; last_hi = -1;
      for (int i = 0; i < 40; i++) begin
         in_tag = TW'(i); in_a = $urandom; in_b = $urandom; in_op = 1'($urandom);
         @(negedge clk);
         check_val("stream_ready", {63'b0, in_ready}, 1);
         if (out_valid) begin
            ov_cnt++; last_hi = cyc;
            if (first_hi < 0) first_hi = cyc;
         end
         cyc++;
         step();
      end
      in_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ov_cnt++; last_hi = cyc;
            if (first_hi < 0) first_hi = cyc;
         end else if (first_hi >= 0) begin
            found = 1;
         end
         cyc++;
      end
      check_val("stream_count", 64'(ov_cnt), 40);
      check_val("stream_contig", 64'(last_hi - first_hi + 1), 40);
      check_val("stream_busy_fall", {63'b0, busy}, 0);
      wait_idle();

      // Overflow flag into the sticky register, then clear it.
      step();
      sticky_clr = 1'b1;
      step();
      sticky_clr = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      in_a = 32'h7F7FFFFF; in_b = 32'h7F7FFFFF; in_op = 1'b0; in_tag = 4'd5;
      step();
      in_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 25 && found == 0; i++) begin
         @(negedge clk);
         if (out_valid) found = 1;
      end
      check_val("ovf_found", 64'(found), 1);
      check_val("ovf_flags", {59'b0, out_flags}, 64'h10);
      @(negedge clk);
      check_val("sticky_set", {59'b0, sticky_flags}, {59'b0, STK_OVF});
      step();
      sticky_clr = 1'b1;
      step();
      sticky_clr = 1'b0;
      @(negedge clk);
      check_val("sticky_cleared", {59'b0, sticky_flags}, 0);

      // Reset while five requests are in flight.
      step();
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_tag = TW'(i); in_a = $urandom; in_b = $urandom;
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      #1;
      check_val("midrst_in_ready", {63'b0, in_ready}, 1);
      check_val("midrst_busy", {63'b0, busy}, 0);
      check_val("midrst_out_valid", {63'b0, out_valid}, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_val("midrst_no_output", {63'b0, out_valid}, 0);
      end

      // Random traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         step();
         in_valid   = ($urandom % 10) < 7;
         out_ready  = ($urandom % 10) < 6;
         sticky_clr = ($urandom % 10) == 0;
         in_a = $urandom; in_b = $urandom; in_op = 1'($urandom); in_tag = TW'($urandom);
      end
      step();
      in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
      wait_idle();
      step();
      check_val("drain_empty", 64'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
